// File: rtl/core_pkg.sv
// Shared core constants: default reservation-station depth and perf-counter width.
package core_pkg;
  localparam int NUM_RS_ENTRIES_DEF = 8;
  localparam int PERF_CNT_W         = 32;
endpackage

// File: rtl/issue_select_if.sv
// Dispatch/issue bundle between the reservation station control and issue_select.
interface issue_select_if
  import core_pkg::*;
#(
  parameter int N = NUM_RS_ENTRIES_DEF
);
  localparam int IDXW = $clog2(N);
  localparam int CNTW = $clog2(N + 1);

  logic                  flush;
  logic                  alloc_valid;
  logic [IDXW-1:0]       alloc_idx;
  logic [N-1:0]          ready_vector;
  logic                  fu_ready;
  logic [N-1:0]          select_lines;
  logic                  select_valid;
  logic [CNTW-1:0]       occupancy;
  logic                  rs_full;
  logic                  alloc_err;
  logic [PERF_CNT_W-1:0] issue_count;
  logic [PERF_CNT_W-1:0] stall_count;

  modport master (
    output flush, alloc_valid, alloc_idx, ready_vector, fu_ready,
    input  select_lines, select_valid, occupancy, rs_full, alloc_err,
           issue_count, stall_count
  );

  modport slave (
    input  flush, alloc_valid, alloc_idx, ready_vector, fu_ready,
    output select_lines, select_valid, occupancy, rs_full, alloc_err,
           issue_count, stall_count
  );
endinterface

// File: rtl/issue_select_age_matrix.sv
// Age matrix (age[i][j] = 1 means entry i is older than entry j) and oldest-ready selection.
module age_matrix
  import core_pkg::*;
#(
  parameter int N = NUM_RS_ENTRIES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en,
  input  logic [$clog2(N)-1:0] alloc_idx,
  input  logic [N-1:0]         keep,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         winner
);
  logic [N-1:0] age [N];
  logic [N-1:0] cand;
  logic [N-1:0] pick;

  // NOTE: the matrix is a storage array but still gets a full reset, because
  // stale ordering bits must not survive a core reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) age[i] <= '0;
    end else if (alloc_en) begin
      for (int i = 0; i < N; i++) begin
        if (i == int'(alloc_idx))
          age[i] <= '0;
        else if (keep[i])
          age[i][alloc_idx] <= 1'b1;
      end
    end
  end

  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand[i] = req[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && req[j] && !age[i][j]) cand[i] = 1'b0;
      end
    end
    // An empty candidate set cannot happen with a consistent matrix; fall back
    // to the requests so the lowest index still wins.
    pick   = (cand != '0) ? cand : req;
    winner = pick & (~pick + N'(1));
  end
endmodule

// File: rtl/issue_select.sv
// Oldest-ready issue select for one FU. Optional perf counters under ISSUE_SELECT_PERF_EN.
module issue_select
  import core_pkg::*;
#(
  parameter int NUM_RS_ENTRIES = NUM_RS_ENTRIES_DEF
) (
  input logic         clk,
  input logic         rst,
  issue_select_if.slave bus
);
  localparam int N    = NUM_RS_ENTRIES;
  localparam int CNTW = $clog2(N + 1);

  logic [N-1:0]    valid;
  logic [N-1:0]    valid_n;
  logic [N-1:0]    req;
  logic [N-1:0]    winner;
  logic [N-1:0]    issued;
  logic [N-1:0]    keep;
  logic [N-1:0]    alloc_vec;
  logic [CNTW-1:0] occ_n;
  logic            fire;
  logic            alloc_hit;
  logic            alloc_ok;

  assign req    = valid & bus.ready_vector;
  assign fire   = bus.fu_ready && (req != '0);
  assign issued = fire ? winner : '0;
  assign keep   = valid & ~issued;

  // An out-of-range index is treated like a collision so it never allocates.
  assign alloc_hit = (int'(bus.alloc_idx) < N) ? valid[bus.alloc_idx] : 1'b1;
  assign alloc_ok  = bus.alloc_valid && !alloc_hit;

  always_comb begin
    alloc_vec = '0;
    if (alloc_ok) alloc_vec[bus.alloc_idx] = 1'b1;
    valid_n = keep | alloc_vec;
    occ_n   = '0;
    for (int i = 0; i < N; i++) occ_n = occ_n + CNTW'(valid_n[i]);
  end

  age_matrix #(.N(N)) u_age (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (alloc_ok && !bus.flush),
    .alloc_idx (bus.alloc_idx),
    .keep      (keep),
    .req       (req),
    .winner    (winner)
  );

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid            <= '0;
      bus.select_lines <= '0;
      bus.select_valid <= 1'b0;
      bus.occupancy    <= '0;
      bus.alloc_err    <= 1'b0;
    end else if (bus.flush) begin
      valid            <= '0;
      bus.select_lines <= '0;
      bus.select_valid <= 1'b0;
      bus.occupancy    <= '0;
    end else begin
      valid            <= valid_n;
      bus.select_lines <= issued;
      bus.select_valid <= fire;
      bus.occupancy    <= occ_n;
      if (bus.alloc_valid && alloc_hit) bus.alloc_err <= 1'b1;
    end
  end

  assign bus.rs_full = (bus.occupancy == CNTW'(N));

`ifdef ISSUE_SELECT_PERF_EN
  logic [PERF_CNT_W-1:0] issue_cnt;
  logic [PERF_CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fire && !bus.flush)             issue_cnt <= issue_cnt + 1'b1;
      if (req != '0 && !bus.fu_ready)     stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.issue_count = issue_cnt;
  assign bus.stall_count = stall_cnt;
`else
  assign bus.issue_count = '0;
  assign bus.stall_count = '0;
`endif
endmodule
